gcd_engine: RTL and testbench
=============================

GCD_ENGINE -- requirements
Module: gcd_engine

Interface
REQ-001 Parameter WIDTH, default 16, sets the operand and result width in bits (minimum 2).
REQ-002 Parameter MODE, default 0, selects the algorithm: 0 = subtractive Euclid, 1 = binary (Stein).
REQ-003 Clock and reset shall be: one clock; reset is asynchronous and active-high (clk, rst).
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  operands a/b are presented.
REQ-007 in_ready  output  1  engine can accept operands; equals (state==IDLE).
REQ-008 a  input  WIDTH  first operand, unsigned.
REQ-009 b  input  WIDTH  second operand, unsigned.
REQ-010 abort  input  1  synchronous cancel of the operation in flight.
REQ-011 out_valid  output  1  gcd_out, cycles and zero_flag are valid.
REQ-012 out_ready  input  1  consumer accepts the result.
REQ-013 gcd_out  output  WIDTH  registered result.
REQ-014 cycles  output  WIDTH+1  number of CALC cycles taken, including the terminating cycle; saturates at all-ones.
REQ-015 zero_flag  output  1  asserted when a==0 and b==0.

Function
REQ-016 The FSM shall have exactly three states: IDLE, CALC and DONE.
REQ-017 In IDLE, in_valid=1 at a clock edge shall latch x=a, y=b, k=0 and cycles=0, and the next state shall be CALC.
REQ-018 Each CALC cycle shall increment cycles and perform exactly one step, tested in priority order:
  - y==0: result = x<<k; go to DONE.
  - x==0: result = y<<k; go to DONE.
  - MODE 0: if x>=y then x=x-y, else y=y-x.
  - MODE 1, both even: x>>=1, y>>=1, k++.
  - MODE 1, x even: x>>=1.
  - MODE 1, y even: y>>=1.
  - MODE 1, both odd: subtract as in MODE 0.
REQ-019 In MODE 0, k shall remain 0; k shall be $clog2(WIDTH)+1 bits wide, and the x<<k shift shall never overflow WIDTH.
REQ-020 On the CALC-to-DONE edge, gcd_out, cycles and zero_flag shall be registered and out_valid shall rise.
REQ-021 In DONE, out_valid, gcd_out, cycles and zero_flag shall stay stable until out_valid&&out_ready, and that edge shall return the FSM to IDLE with out_valid=0.
REQ-022 There shall be no IDLE bypass: a new operand pair is accepted no earlier than the cycle after the result handshake.
REQ-023 Boundary cases shall resolve in the first CALC cycle:
  - gcd(0,0)=0 with zero_flag=1.
  - gcd(n,0)=gcd(0,n)=n with zero_flag=0.
REQ-024 abort=1 in CALC or DONE shall return the FSM to IDLE at the next edge with out_valid=0; abort in IDLE shall have no effect; abort shall take priority over a simultaneous out_ready.
REQ-025 in_valid outside IDLE shall be ignored, and a/b need only be held for the accepting edge.
REQ-026 All arithmetic shall be unsigned with no wrap-around; x-y shall be computed only when x>=y.

Reset
REQ-027 While rst=1, state shall be IDLE, and x, y, k, gcd_out, cycles, zero_flag and out_valid shall be 0.
REQ-028 While rst=1, no operands shall be accepted (even though in_ready reads 1).
REQ-029 Reset asserted mid-CALC or mid-DONE shall discard the operation immediately, with no result emitted afterwards.
REQ-030 After reset release, the first operands may be accepted on the first rising edge.

Structure
REQ-031 Shared package gcd_pkg shall hold the state encoding (IDLE/CALC/DONE) and the constants MODE_EUCLID=0 and MODE_STEIN=1, for reuse by sibling GCD blocks.
REQ-032 One combinational sub-module, gcd_step (parameters WIDTH, MODE), shall compute next x, y, k and done/result from the current x, y, k.
REQ-033 gcd_engine shall hold only the FSM, registers and handshake.

Verification
REQ-034 MODE 0, a=48, b=18, out_ready=1 -> gcd_out=6, cycles=6, zero_flag=0.
REQ-035 MODE 0, a=143, b=72 -> gcd_out=1, cycles=74; MODE 0, a=100, b=0 -> gcd_out=100, cycles=1.
REQ-036 MODE 1, a=48, b=18 -> gcd_out=6, cycles=8; MODE 1, a=270, b=192 -> gcd_out=6.
REQ-037 a=0, b=0 (either mode) -> gcd_out=0, zero_flag=1, cycles=1.
REQ-038 MODE 0, 56/98 with out_ready held low for 5 cycles after out_valid -> gcd_out=14 stable throughout, in_ready=0, and a second in_valid is ignored until the handshake.
REQ-039 rst asserted, then separately abort asserted, 3 cycles into 143/72 -> out_valid stays 0, in_ready=1 next cycle, and the following 48/18 yields 6.

Source files
------------

// File: rtl/gcd_pkg.sv
// gcd_pkg: shared state encoding and algorithm selectors for GCD blocks
package gcd_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  localparam int MODE_EUCLID = 0;
  localparam int MODE_STEIN = 1;
endpackage

// File: rtl/gcd_step.sv
// gcd_step: one combinational GCD iteration (subtractive Euclid or binary Stein)
module gcd_step
  import gcd_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int MODE = MODE_EUCLID,
  localparam int KW = $clog2(WIDTH) + 1
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [KW-1:0]    k,
  output logic [WIDTH-1:0] nx,
  output logic [WIDTH-1:0] ny,
  output logic [KW-1:0]    nk,
  output logic             done,
  output logic [WIDTH-1:0] result
);
  // a zero operand terminates; otherwise strip common/lone factors of two (Stein) or subtract the smaller
  always_comb begin
    nx = x;
    ny = y;
    nk = k;
    done = 1'b0;
    result = '0;
    if (y == '0) begin
      done = 1'b1;
      result = x << k;
    end else if (x == '0) begin
      done = 1'b1;
      result = y << k;
    end else if (MODE == MODE_STEIN && !x[0] && !y[0]) begin
      nx = x >> 1;
      ny = y >> 1;
      nk = k + KW'(1);
    end else if (MODE == MODE_STEIN && !x[0]) nx = x >> 1;
    else if (MODE == MODE_STEIN && !y[0]) ny = y >> 1;
    else if (x >= y) nx = x - y;
    else ny = y - x;
  end
endmodule

// File: rtl/gcd_engine.sv
// gcd_engine: handshaked multi-cycle GCD with cycle count and abort
module gcd_engine #(
  parameter int WIDTH = 16,
  parameter int MODE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] gcd_out,
  output logic [WIDTH:0]   cycles,
  output logic             zero_flag
);
  import gcd_pkg::*;
  localparam int KW = $clog2(WIDTH) + 1;
  state_t state, state_nx;
  logic [WIDTH-1:0] x, y, nx, ny, result;
  logic [KW-1:0] k, nk;
  logic done;
  gcd_step #(.WIDTH(WIDTH), .MODE(MODE)) u_step (
    .x(x), .y(y), .k(k), .nx(nx), .ny(ny), .nk(nk), .done(done), .result(result)
  );
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_nx;
  end
  // abort outranks both the step result and the output handshake
  always_comb begin
    state_nx = state;
    if (state == IDLE) state_nx = in_valid ? CALC : IDLE;
    else if (abort) state_nx = IDLE;
    else if (state == CALC) state_nx = done ? DONE : CALC;
    else state_nx = out_ready ? IDLE : DONE;
  end
  // operand latch, iteration registers, saturating cycle count and result capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x <= '0;
      y <= '0;
      k <= '0;
      cycles <= '0;
      gcd_out <= '0;
      zero_flag <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      x <= a;
      y <= b;
      k <= '0;
      cycles <= '0;
    end else if (state == CALC && !abort) begin
      x <= nx;
      y <= ny;
      k <= nk;
      cycles <= &cycles ? cycles : cycles + (WIDTH + 1)'(1);
      if (done) begin
        gcd_out <= result;
        zero_flag <= result == '0;
      end
    end
  end
endmodule

// File: tb/tb_gcd_engine.sv
// tb_gcd_engine: randomized and directed checks of both GCD modes against an arithmetic model
module tb_gcd_engine;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid [2];
  logic in_ready [2];
  logic [15:0] a [2];
  logic [15:0] b [2];
  logic abort [2];
  logic out_valid [2];
  logic out_ready [2];
  logic [15:0] gcd_out [2];
  logic [16:0] cycles [2];
  logic zero_flag [2];
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  gcd_engine #(.WIDTH(16), .MODE(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .a(a[0]), .b(b[0]),
    .abort(abort[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]), .gcd_out(gcd_out[0]),
    .cycles(cycles[0]), .zero_flag(zero_flag[0])
  );
  gcd_engine #(.WIDTH(16), .MODE(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .a(a[1]), .b(b[1]),
    .abort(abort[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]), .gcd_out(gcd_out[1]),
    .cycles(cycles[1]), .zero_flag(zero_flag[1])
  );

  function automatic longint ref_gcd(longint p, longint q);
    longint t;
    while (q != 0) begin
      t = p % q;
      p = q;
      q = t;
    end
    return p;
  endfunction

  // subtractive Euclid takes one CALC cycle per unit of quotient, plus the terminating cycle
  function automatic longint ref_cyc0(longint p, longint q);
    longint s = 0;
    longint t;
    if (p == 0 || q == 0) return 1;
    while (q != 0) begin
      s += p / q;
      t = p % q;
      p = q;
      q = t;
    end
    return s + 1;
  endfunction

  task automatic check(input string tag, input longint obs, input longint exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic finish_op(input int m, input longint eg, input longint ec, input longint ez);
    for (int i = 0; i < 5000 && out_valid[m] !== 1'b1; i++) @(negedge clk);
    check("out_valid", out_valid[m], 1);
    check("gcd", gcd_out[m], eg);
    if (ec >= 0) check("cycles", cycles[m], ec);
    check("zero_flag", zero_flag[m], ez);
    out_ready[m] = 1'b1;
    @(negedge clk);
    out_ready[m] = 1'b0;
    check("release", out_valid[m], 0);
    check("ready_after", in_ready[m], 1);
  endtask

  task automatic op(input int m, input logic [15:0] av, input logic [15:0] bv, input longint ec);
    check("in_ready", in_ready[m], 1);
    a[m] = av;
    b[m] = bv;
    in_valid[m] = 1'b1;
    @(negedge clk);
    in_valid[m] = 1'b0;
    a[m] = 16'($urandom);
    b[m] = 16'($urandom);
    finish_op(m, ref_gcd(av, bv), ec, (av == 0 && bv == 0) ? 1 : 0);
  endtask

  initial begin
    logic [15:0] ra, rb;
    for (int m = 0; m < 2; m++) begin
      in_valid[m] = 1'b1;
      a[m] = 16'd5;
      b[m] = 16'd3;
      abort[m] = 1'b0;
      out_ready[m] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      check("rst_in_ready", in_ready[m], 1);
      check("rst_out_valid", out_valid[m], 0);
      check("rst_gcd", gcd_out[m], 0);
      check("rst_cycles", cycles[m], 0);
      check("rst_zero", zero_flag[m], 0);
      in_valid[m] = 1'b0;
    end
    rst = 1'b0;
    op(0, 16'd48, 16'd18, 6);
    op(0, 16'd143, 16'd72, 74);
    op(0, 16'd100, 16'd0, 1);
    op(0, 16'd0, 16'd37, 1);
    op(0, 16'd0, 16'd0, 1);
    op(1, 16'd48, 16'd18, 8);
    op(1, 16'd270, 16'd192, -1);
    op(1, 16'd0, 16'd0, 1);
    op(1, 16'd0, 16'd55, 1);
    // result held while the consumer stalls; extra operands ignored
    a[0] = 16'd56;
    b[0] = 16'd98;
    in_valid[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    for (int i = 0; i < 500 && out_valid[0] !== 1'b1; i++) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      a[0] = 16'd48;
      b[0] = 16'd18;
      in_valid[0] = 1'b1;
      check("hold_valid", out_valid[0], 1);
      check("hold_gcd", gcd_out[0], 14);
      check("hold_cycles", cycles[0], ref_cyc0(56, 98));
      check("hold_in_ready", in_ready[0], 0);
      @(negedge clk);
    end
    in_valid[0] = 1'b0;
    finish_op(0, 14, ref_cyc0(56, 98), 0);
    // reset in the middle of a computation
    a[0] = 16'd143;
    b[0] = 16'd72;
    in_valid[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", out_valid[0], 0);
    check("mid_rst_ready", in_ready[0], 1);
    @(negedge clk);
    rst = 1'b0;
    repeat (80) @(negedge clk);
    check("mid_rst_quiet", out_valid[0], 0);
    op(0, 16'd48, 16'd18, 6);
    // abort in the middle of a computation
    a[0] = 16'd143;
    b[0] = 16'd72;
    in_valid[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (3) @(negedge clk);
    abort[0] = 1'b1;
    @(negedge clk);
    abort[0] = 1'b0;
    check("abort_valid", out_valid[0], 0);
    check("abort_ready", in_ready[0], 1);
    repeat (80) @(negedge clk);
    check("abort_quiet", out_valid[0], 0);
    op(0, 16'd48, 16'd18, 6);
    // abort while idle is ignored
    abort[1] = 1'b1;
    a[1] = 16'd48;
    b[1] = 16'd18;
    in_valid[1] = 1'b1;
    @(negedge clk);
    abort[1] = 1'b0;
    in_valid[1] = 1'b0;
    finish_op(1, 6, 8, 0);
    // abort beats out_ready in DONE
    a[1] = 16'd12;
    b[1] = 16'd8;
    in_valid[1] = 1'b1;
    @(negedge clk);
    in_valid[1] = 1'b0;
    for (int i = 0; i < 500 && out_valid[1] !== 1'b1; i++) @(negedge clk);
    check("done_abort_pre", out_valid[1], 1);
    abort[1] = 1'b1;
    out_ready[1] = 1'b1;
    @(negedge clk);
    abort[1] = 1'b0;
    out_ready[1] = 1'b0;
    check("done_abort_valid", out_valid[1], 0);
    check("done_abort_ready", in_ready[1], 1);
    for (int i = 0; i < 25; i++) begin
      ra = 16'($urandom_range(0, 1023));
      rb = 16'($urandom_range(0, 1023));
      if (i % 8 == 3) rb = 16'd0;
      op(0, ra, rb, ref_cyc0(ra, rb));
    end
    for (int i = 0; i < 25; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (i % 4 == 1) begin
        ra = ra << $urandom_range(0, 6);
        rb = rb << $urandom_range(0, 6);
      end
      if (i % 8 == 5) ra = 16'd0;
      op(1, ra, rb, -1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
